reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 26 ++
 rtl/register_status_table.sv | 92 +++++++++
 rtl/reorder_buffer.sv | 178 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer slice (the parameters.v values).
//   WORD_SIZE  data width
//   RB_SIZE    number of reorder buffer entries (tags 0..RB_SIZE-1)
//   RB_INDEX   tag width
//   FU_NUM     number of functional units driving the result buses
//   REG_INDEX  architectural register index width
//   READY/NULL tag values outside 0..RB_SIZE-1
package reorder_buffer_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned RB_SIZE   = 8;
  localparam int unsigned RB_INDEX  = 4;
  localparam int unsigned FU_NUM    = 4;
  localparam int unsigned REG_INDEX = 5;

  // Operand value is available (no pending producer).
  localparam logic [RB_INDEX-1:0] READY = 4'd14;
  // Functional unit result carries no destination tag.
  localparam logic [RB_INDEX-1:0] NULL  = 4'd15;

  // Circular pointer increment, wrapping from size-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned size);
    return (ptr + 1 == size) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/register_status_table.sv
// Register status table: one producer tag per architectural register, plus
// the combinational operand lookup for the two source ports j and k.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   alloc_en/reg/tag         new producer for alloc_reg
//   commit_en/reg/tag        entry commit_tag retiring into commit_reg
//   entry_done/entry_value   per-entry busy&done flag and result
//   reg_numj/k, rf_dataj/k   lookup registers and their register-file values
//   vj/vk, qj/qk             operand values and tags (READY when available)
module register_status_table #(
  parameter int unsigned WORD_SIZE = reorder_buffer_pkg::WORD_SIZE,
  parameter int unsigned RB_SIZE   = reorder_buffer_pkg::RB_SIZE,
  parameter int unsigned RB_INDEX  = reorder_buffer_pkg::RB_INDEX,
  parameter int unsigned REG_INDEX = reorder_buffer_pkg::REG_INDEX
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_en,
  input  logic [REG_INDEX-1:0]          alloc_reg,
  input  logic [RB_INDEX-1:0]           alloc_tag,
  input  logic                          commit_en,
  input  logic [REG_INDEX-1:0]          commit_reg,
  input  logic [RB_INDEX-1:0]           commit_tag,
  input  logic [RB_SIZE-1:0]            entry_done,
  input  logic [WORD_SIZE*RB_SIZE-1:0]  entry_value,
  input  logic [REG_INDEX-1:0]          reg_numj,
  input  logic [REG_INDEX-1:0]          reg_numk,
  input  logic [WORD_SIZE-1:0]          rf_dataj,
  input  logic [WORD_SIZE-1:0]          rf_datak,
  output logic [WORD_SIZE-1:0]          vj,
  output logic [WORD_SIZE-1:0]          vk,
  output logic [RB_INDEX-1:0]           qj,
  output logic [RB_INDEX-1:0]           qk
);
  import reorder_buffer_pkg::*;

  localparam int unsigned NUM_REGS = 2 ** REG_INDEX;
  localparam int unsigned PW = (RB_SIZE > 1) ? $clog2(RB_SIZE) : 1;
  localparam logic [RB_INDEX-1:0] TAG_READY = RB_INDEX'(READY);

  logic [NUM_REGS-1:0][RB_INDEX-1:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    // Only release the register if no younger producer has claimed it.
    if (commit_en && stat_q[commit_reg] == commit_tag) begin
      stat_d[commit_reg] = TAG_READY;
    end
    // Applied last so a same-cycle allocation overrides the commit release.
    if (alloc_en) begin
      stat_d[alloc_reg] = alloc_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q <= {NUM_REGS{TAG_READY}};
    end else begin
      stat_q <= stat_d;
    end
  end

  function automatic void lookup(input  logic [RB_INDEX-1:0]          stat,
                                 input  logic [WORD_SIZE-1:0]         rf,
                                 input  logic [RB_SIZE-1:0]           done,
                                 input  logic [WORD_SIZE*RB_SIZE-1:0] values,
                                 output logic [RB_INDEX-1:0]          q,
                                 output logic [WORD_SIZE-1:0]         v);
    int unsigned idx;
    idx = 32'(stat[PW-1:0]);
    q = stat;
    v = '0;
    if (stat == TAG_READY) begin
      q = TAG_READY;
      v = rf;
    end else if (stat < RB_INDEX'(RB_SIZE) && done[idx]) begin
      // Producer finished but not yet committed: forward its result.
      q = TAG_READY;
      v = values[idx*WORD_SIZE +: WORD_SIZE];
    end
  endfunction

  always_comb begin
    qj = '0;
    vj = '0;
    qk = '0;
    vk = '0;
    lookup(stat_q[reg_numj], rf_dataj, entry_done, entry_value, qj, vj);
    lookup(stat_q[reg_numk], rf_datak, entry_done, entry_value, qk, vk);
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular buffer of in-flight instructions. Entries are
// allocated in order at the tail, filled out of order by the functional-unit
// result buses, and committed in order from the head, one per cycle.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   alloc_req/alloc_reg               issue request and its destination register
//   alloc_ready/alloc_index           not-full flag and tag granted (tail)
//   data_bus/valid_bus/RB_index_bus   per-FU result, valid and destination tag
//   CDB_data_data/CDB_data_valid      per-entry registered result and busy&done
//   reg_numj/k, rf_dataj/k            operand lookup inputs
//   vj/vk, qj/qk                      operand values and tags
//   commit_valid/reg/data             registered one-cycle commit strobe
module reorder_buffer #(
  parameter int unsigned WORD_SIZE = reorder_buffer_pkg::WORD_SIZE,
  parameter int unsigned RB_SIZE   = reorder_buffer_pkg::RB_SIZE,
  parameter int unsigned RB_INDEX  = reorder_buffer_pkg::RB_INDEX,
  parameter int unsigned FU_NUM    = reorder_buffer_pkg::FU_NUM,
  parameter int unsigned REG_INDEX = reorder_buffer_pkg::REG_INDEX
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_req,
  input  logic [REG_INDEX-1:0]          alloc_reg,
  output logic                          alloc_ready,
  output logic [RB_INDEX-1:0]           alloc_index,
  input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
  input  logic [FU_NUM-1:0]             valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
  output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  input  logic [REG_INDEX-1:0]          reg_numj,
  input  logic [REG_INDEX-1:0]          reg_numk,
  input  logic [WORD_SIZE-1:0]          rf_dataj,
  input  logic [WORD_SIZE-1:0]          rf_datak,
  output logic [WORD_SIZE-1:0]          vj,
  output logic [WORD_SIZE-1:0]          vk,
  output logic [RB_INDEX-1:0]           qj,
  output logic [RB_INDEX-1:0]           qk,
  output logic                          commit_valid,
  output logic [REG_INDEX-1:0]          commit_reg,
  output logic [WORD_SIZE-1:0]          commit_data
);
  import reorder_buffer_pkg::*;

  localparam int unsigned PW = (RB_SIZE > 1) ? $clog2(RB_SIZE) : 1;
  localparam int unsigned CW = $clog2(RB_SIZE + 1);
  localparam logic [RB_INDEX-1:0] TAG_NULL = RB_INDEX'(NULL);

  logic [RB_SIZE-1:0]                busy_q, busy_d, done_q, done_d;
  logic [RB_SIZE-1:0][REG_INDEX-1:0] dest_q, dest_d;
  logic [RB_SIZE-1:0][WORD_SIZE-1:0] value_q, value_d;
  logic [PW-1:0]                     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                     count_q, count_d;
  logic                              commit_valid_q, commit_valid_d;
  logic [REG_INDEX-1:0]              commit_reg_q, commit_reg_d;
  logic [WORD_SIZE-1:0]              commit_data_q, commit_data_d;

  logic                alloc_fire, commit_fire;
  logic [RB_INDEX-1:0] wb_tag;
  logic [PW-1:0]       wb_idx;

  assign alloc_ready = (count_q != CW'(RB_SIZE));
  assign alloc_fire  = alloc_req && alloc_ready;
  assign commit_fire = busy_q[head_q] && done_q[head_q];
  assign alloc_index = RB_INDEX'(tail_q);

  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    dest_d         = dest_q;
    value_d        = value_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_reg_d   = '0;
    commit_data_d  = '0;
    wb_tag         = '0;
    wb_idx         = '0;

    // Walk FUs from highest to lowest so the lowest-numbered FU writes last.
    // Busy is taken from registered state, so an entry allocated this cycle
    // ignores writeback.
    for (int f = FU_NUM - 1; f >= 0; f--) begin
      wb_tag = RB_index_bus[f*RB_INDEX +: RB_INDEX];
      wb_idx = wb_tag[PW-1:0];
      if (valid_bus[f] && wb_tag != TAG_NULL && wb_tag < RB_INDEX'(RB_SIZE) && busy_q[wb_idx])
      begin
        value_d[wb_idx] = data_bus[f*WORD_SIZE +: WORD_SIZE];
        done_d[wb_idx]  = 1'b1;
      end
    end

    if (commit_fire) begin
      commit_valid_d  = 1'b1;
      commit_reg_d    = dest_q[head_q];
      commit_data_d   = value_q[head_q];
      busy_d[head_q]  = 1'b0;
      done_d[head_q]  = 1'b0;
      dest_d[head_q]  = '0;
      value_d[head_q] = '0;
      head_d          = PW'(wrap_inc(32'(head_q), RB_SIZE));
    end

    if (alloc_fire) begin
      busy_d[tail_q]  = 1'b1;
      done_d[tail_q]  = 1'b0;
      dest_d[tail_q]  = alloc_reg;
      value_d[tail_q] = '0;
      tail_d          = PW'(wrap_inc(32'(tail_q), RB_SIZE));
    end

    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q         <= '0;
      done_q         <= '0;
      dest_q         <= '0;
      value_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
      commit_data_q  <= '0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      dest_q         <= dest_d;
      value_q        <= value_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q   <= commit_reg_d;
      commit_data_q  <= commit_data_d;
    end
  end

  assign CDB_data_valid = busy_q & done_q;
  assign CDB_data_data  = value_q;
  assign commit_valid   = commit_valid_q;
  assign commit_reg     = commit_reg_q;
  assign commit_data    = commit_data_q;

  register_status_table #(
    .WORD_SIZE (WORD_SIZE),
    .RB_SIZE   (RB_SIZE),
    .RB_INDEX  (RB_INDEX),
    .REG_INDEX (REG_INDEX)
  ) u_register_status_table (
    .clk         (clk),
    .reset       (reset),
    .alloc_en    (alloc_fire),
    .alloc_reg   (alloc_reg),
    .alloc_tag   (alloc_index),
    .commit_en   (commit_fire),
    .commit_reg  (dest_q[head_q]),
    .commit_tag  (RB_INDEX'(head_q)),
    .entry_done  (CDB_data_valid),
    .entry_value (CDB_data_data),
    .reg_numj    (reg_numj),
    .reg_numk    (reg_numk),
    .rf_dataj    (rf_dataj),
    .rf_datak    (rf_datak),
    .vj          (vj),
    .vk          (vk),
    .qj          (qj),
    .qk          (qk)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  localparam int W  = reorder_buffer_pkg::WORD_SIZE;
  localparam int RB = reorder_buffer_pkg::RB_SIZE;
  localparam int RI = reorder_buffer_pkg::RB_INDEX;
  localparam int FU = reorder_buffer_pkg::FU_NUM;
  localparam int RG = reorder_buffer_pkg::REG_INDEX;
  localparam int NR = 2 ** RG;
  localparam logic [RI-1:0] T_READY = reorder_buffer_pkg::READY;
  localparam logic [RI-1:0] T_NULL  = reorder_buffer_pkg::NULL;

  logic            clk = 1'b0;
  logic            reset;
  logic            alloc_req;
  logic [RG-1:0]   alloc_reg;
  logic            alloc_ready;
  logic [RI-1:0]   alloc_index;
  logic [FU*W-1:0] data_bus;
  logic [FU-1:0]   valid_bus;
  logic [FU*RI-1:0] RB_index_bus;
  logic [W*RB-1:0] CDB_data_data;
  logic [RB-1:0]   CDB_data_valid;
  logic [RG-1:0]   reg_numj, reg_numk;
  logic [W-1:0]    rf_dataj, rf_datak, vj, vk;
  logic [RI-1:0]   qj, qk;
  logic            commit_valid;
  logic [RG-1:0]   commit_reg;
  logic [W-1:0]    commit_data;

  int total = 0;
  int bad = 0;

  reorder_buffer dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_reg(alloc_reg),
    .alloc_ready(alloc_ready), .alloc_index(alloc_index), .data_bus(data_bus),
    .valid_bus(valid_bus), .RB_index_bus(RB_index_bus), .CDB_data_data(CDB_data_data),
    .CDB_data_valid(CDB_data_valid), .reg_numj(reg_numj), .reg_numk(reg_numk),
    .rf_dataj(rf_dataj), .rf_datak(rf_datak), .vj(vj), .vk(vk), .qj(qj), .qk(qk),
    .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_data(commit_data)
  );

  always #5 clk = ~clk;

  // Reference model: in-order queue of live tags plus per-tag result records.
  int         inflight[$];
  int         next_tag;
  bit         m_busy[RB];
  bit         m_done[RB];
  int         m_dest[RB];
  logic [W-1:0] m_val[RB];
  int         m_stat[NR];  // -1 means value is in the register file
  bit         m_cv;
  int         m_creg;
  logic [W-1:0] m_cdata;

  task automatic model_clear();
    inflight.delete();
    next_tag = 0;
    for (int i = 0; i < RB; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_dest[i] = 0; m_val[i] = '0;
    end
    for (int r = 0; r < NR; r++) m_stat[r] = -1;
    m_cv = 0; m_creg = 0; m_cdata = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit do_commit, do_alloc;
    bit claimed[RB];
    int h, t;
    do_commit = inflight.size() > 0 && m_done[inflight[0]];
    do_alloc  = alloc_req && inflight.size() < RB;
    m_cv = 0;
    if (do_commit) begin
      h = inflight[0];
      m_cv = 1; m_creg = m_dest[h]; m_cdata = m_val[h];
    end
    for (int i = 0; i < RB; i++) claimed[i] = 0;
    for (int f = 0; f < FU; f++) begin
      t = int'(RB_index_bus[f*RI +: RI]);
      if (valid_bus[f] && t < RB && m_busy[t] && !claimed[t]) begin
        claimed[t] = 1; m_done[t] = 1; m_val[t] = data_bus[f*W +: W];
      end
    end
    if (do_commit) begin
      h = inflight.pop_front();
      m_busy[h] = 0; m_done[h] = 0; m_val[h] = '0;
      if (m_stat[m_creg] == h) m_stat[m_creg] = -1;
    end
    if (do_alloc) begin
      m_busy[next_tag] = 1; m_done[next_tag] = 0; m_val[next_tag] = '0;
      m_dest[next_tag] = int'(alloc_reg);
      m_stat[alloc_reg] = next_tag;
      inflight.push_back(next_tag);
      next_tag = (next_tag + 1) % RB;
    end
  endtask

  task automatic model_lookup(input int r, input logic [W-1:0] rf,
                              output logic [RI-1:0] q, output logic [W-1:0] v);
    int s;
    s = m_stat[r];
    if (s < 0) begin q = T_READY; v = rf; end
    else if (m_done[s]) begin q = T_READY; v = m_val[s]; end
    else begin q = RI'(s); v = '0; end
  endtask

  task automatic idle_inputs();
    alloc_req = 0; alloc_reg = '0; valid_bus = '0; data_bus = '0;
    RB_index_bus = {FU{T_NULL}};
    reg_numj = '0; reg_numk = '0; rf_dataj = '0; rf_datak = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    alloc_req = 0; valid_bus = '0; RB_index_bus = {FU{T_NULL}};
  endtask

  task automatic set_fu(input int f, input int tag, input logic [W-1:0] d);
    valid_bus[f] = 1'b1;
    RB_index_bus[f*RI +: RI] = RI'(tag);
    data_bus[f*W +: W] = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1; #1;
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", alloc_ready); end
    total++; if (alloc_index !== '0) begin bad++; $display("FAIL reset_index got=%0h exp=0", alloc_index); end
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL reset_commit got=%0b exp=0", commit_valid); end
    total++; if (CDB_data_valid !== '0) begin bad++; $display("FAIL reset_cdbv got=%0h exp=0", CDB_data_valid); end
    total++; if (CDB_data_data !== '0) begin bad++; $display("FAIL reset_cdbd got=%0h exp=0", CDB_data_data); end
    total++; if (qj !== T_READY) begin bad++; $display("FAIL reset_qj got=%0h exp=%0h", qj, T_READY); end
    @(posedge clk); #1; reset = 0; #1;
  endtask

  task automatic test_basic();
    do_reset();
    alloc_req = 1; alloc_reg = 3; #1;
    total++; if (alloc_index !== 0) begin bad++; $display("FAIL basic_idx0 got=%0h exp=0", alloc_index); end
    tick();
    alloc_req = 1; alloc_reg = 5; #1;
    total++; if (alloc_index !== 1) begin bad++; $display("FAIL basic_idx1 got=%0h exp=1", alloc_index); end
    tick();
    reg_numj = 3; reg_numk = 5; #1;
    total++; if (qj !== 0) begin bad++; $display("FAIL basic_qj_r3 got=%0h exp=0", qj); end
    total++; if (qk !== 1) begin bad++; $display("FAIL basic_qk_r5 got=%0h exp=1", qk); end
    set_fu(1, 0, 32'h2A);
    tick();
    total++; if (CDB_data_valid[0] !== 1'b1) begin bad++; $display("FAIL basic_cdbv got=%0b exp=1", CDB_data_valid[0]); end
    total++; if (CDB_data_data[W-1:0] !== 32'h2A) begin bad++; $display("FAIL basic_cdbd got=%0h exp=2a", CDB_data_data[W-1:0]); end
    total++; if (qj !== T_READY || vj !== 32'h2A) begin bad++; $display("FAIL basic_fwd got=%0h/%0h exp=%0h/2a", qj, vj, T_READY); end
    tick();
    rf_dataj = 32'h77; #1;
    total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL basic_cv got=%0b exp=1", commit_valid); end
    total++; if (commit_reg !== 3 || commit_data !== 32'h2A) begin bad++; $display("FAIL basic_commit got=%0d/%0h exp=3/2a", commit_reg, commit_data); end
    total++; if (qj !== T_READY || vj !== 32'h77) begin bad++; $display("FAIL basic_rf got=%0h/%0h exp=%0h/77", qj, vj, T_READY); end
    tick();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL basic_cv_pulse got=%0b exp=0", commit_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < RB; i++) begin
      alloc_req = 1; alloc_reg = RG'(i + 1); tick();
    end
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b exp=0", alloc_ready); end
    alloc_req = 1; alloc_reg = 20; #1;
    total++; if (alloc_index !== 0) begin bad++; $display("FAIL full_idx got=%0h exp=0", alloc_index); end
    tick();
    reg_numj = 20; #1;
    total++; if (alloc_ready !== 1'b0 || qj !== T_READY) begin bad++; $display("FAIL full_ignored got=%0b/%0h exp=0/%0h", alloc_ready, qj, T_READY); end
    set_fu(0, 0, 32'h55); tick();
    alloc_req = 1; alloc_reg = 21; tick();
    reg_numj = 21; #1;
    total++; if (commit_valid !== 1'b1 || commit_reg !== 1) begin bad++; $display("FAIL full_commit got=%0b/%0d exp=1/1", commit_valid, commit_reg); end
    total++; if (alloc_ready !== 1'b1 || qj !== T_READY) begin bad++; $display("FAIL full_same_edge got=%0b/%0h exp=1/%0h", alloc_ready, qj, T_READY); end
    alloc_req = 1; alloc_reg = 22; #1;
    total++; if (alloc_index !== 0) begin bad++; $display("FAIL wrap_idx got=%0h exp=0", alloc_index); end
    tick();
    reg_numj = 22; #1;
    total++; if (alloc_ready !== 1'b0 || qj !== 0) begin bad++; $display("FAIL wrap_full got=%0b/%0h exp=0/0", alloc_ready, qj); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc_req = 1; alloc_reg = 1; tick();
    alloc_req = 1; alloc_reg = 2; tick();
    set_fu(0, 1, 32'h11); tick();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL ooo_wait1 got=%0b exp=0", commit_valid); end
    tick();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL ooo_wait2 got=%0b exp=0", commit_valid); end
    set_fu(2, 0, 32'h99); set_fu(0, 0, 32'h10); tick();
    total++; if (CDB_data_data[W-1:0] !== 32'h10) begin bad++; $display("FAIL ooo_lowest_fu got=%0h exp=10", CDB_data_data[W-1:0]); end
    tick();
    total++; if (commit_valid !== 1'b1 || commit_reg !== 1 || commit_data !== 32'h10) begin bad++; $display("FAIL ooo_first got=%0b/%0d/%0h exp=1/1/10", commit_valid, commit_reg, commit_data); end
    tick();
    total++; if (commit_valid !== 1'b1 || commit_reg !== 2 || commit_data !== 32'h11) begin bad++; $display("FAIL ooo_second got=%0b/%0d/%0h exp=1/2/11", commit_valid, commit_reg, commit_data); end
    tick();
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL ooo_end got=%0b exp=0", commit_valid); end
  endtask

  task automatic test_stat_realloc();
    do_reset();
    alloc_req = 1; alloc_reg = 4; tick();
    alloc_req = 1; alloc_reg = 4; tick();
    reg_numj = 4; #1;
    total++; if (qj !== 1) begin bad++; $display("FAIL realloc_q got=%0h exp=1", qj); end
    set_fu(3, 0, 32'hAB); tick(); tick();
    total++; if (commit_valid !== 1'b1 || commit_reg !== 4) begin bad++; $display("FAIL realloc_commit got=%0b/%0d exp=1/4", commit_valid, commit_reg); end
    total++; if (qj !== 1 || vj !== '0) begin bad++; $display("FAIL realloc_stat got=%0h/%0h exp=1/0", qj, vj); end
  endtask

  task automatic test_reset_midway();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_req = 1; alloc_reg = RG'(6 + i); tick();
    end
    set_fu(0, 1, 32'h101); set_fu(1, 2, 32'h202); tick();
    total++; if (CDB_data_valid !== RB'(6)) begin bad++; $display("FAIL mid_pre got=%0h exp=6", CDB_data_valid); end
    reset = 1; #1;
    total++; if (CDB_data_valid !== '0 || CDB_data_data !== '0) begin bad++; $display("FAIL mid_async got=%0h/%0h exp=0/0", CDB_data_valid, CDB_data_data); end
    @(posedge clk); #1;
    reset = 0; model_clear(); reg_numj = 7; #1;
    total++; if (alloc_index !== 0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL mid_after got=%0h/%0b exp=0/1", alloc_index, alloc_ready); end
    total++; if (qj !== T_READY) begin bad++; $display("FAIL mid_stat got=%0h exp=%0h", qj, T_READY); end
  endtask

  task automatic test_random();
    logic [RI-1:0] eq;
    logic [W-1:0]  ev;
    logic [W*RB-1:0] ed;
    logic [RB-1:0] evl;
    int cand[$];
    int sel, t;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      alloc_req = ($urandom_range(0, 9) < 5);
      alloc_reg = RG'($urandom_range(0, NR - 1));
      cand.delete();
      foreach (inflight[i]) if (!m_done[inflight[i]]) cand.push_back(inflight[i]);
      valid_bus = '0;
      RB_index_bus = {FU{T_NULL}};
      for (int f = 0; f < FU; f++) begin
        data_bus[f*W +: W] = $urandom;
        if ($urandom_range(0, 9) < 4) begin
          sel = $urandom_range(0, 9);
          if (sel < 7 && cand.size() > 0) t = cand[$urandom_range(0, cand.size() - 1)];
          else begin
            t = $urandom_range(0, RB - 1);
            if (m_busy[t] || sel == 9) t = int'(T_NULL);
          end
          valid_bus[f] = 1'b1;
          RB_index_bus[f*RI +: RI] = RI'(t);
        end
      end
      reg_numj = RG'($urandom_range(0, NR - 1));
      reg_numk = RG'($urandom_range(0, NR - 1));
      rf_dataj = $urandom;
      rf_datak = $urandom;
      #1;
      for (int i = 0; i < RB; i++) begin
        ed[i*W +: W] = m_val[i];
        evl[i] = m_busy[i] & m_done[i];
      end
      total++; if (alloc_ready !== (inflight.size() != RB)) begin bad++; $display("FAIL rnd_ready n=%0d got=%0b", n, alloc_ready); end
      total++; if (alloc_index !== RI'(next_tag)) begin bad++; $display("FAIL rnd_index n=%0d got=%0h exp=%0h", n, alloc_index, next_tag); end
      total++; if (CDB_data_valid !== evl) begin bad++; $display("FAIL rnd_cdbv n=%0d got=%0h exp=%0h", n, CDB_data_valid, evl); end
      total++; if (CDB_data_data !== ed) begin bad++; $display("FAIL rnd_cdbd n=%0d got=%0h exp=%0h", n, CDB_data_data, ed); end
      total++; if (commit_valid !== m_cv) begin bad++; $display("FAIL rnd_cv n=%0d got=%0b exp=%0b", n, commit_valid, m_cv); end
      if (m_cv) begin
        total++; if (commit_reg !== RG'(m_creg) || commit_data !== m_cdata) begin bad++; $display("FAIL rnd_commit n=%0d got=%0d/%0h exp=%0d/%0h", n, commit_reg, commit_data, m_creg, m_cdata); end
      end
      model_lookup(int'(reg_numj), rf_dataj, eq, ev);
      total++; if (qj !== eq || vj !== ev) begin bad++; $display("FAIL rnd_j n=%0d got=%0h/%0h exp=%0h/%0h", n, qj, vj, eq, ev); end
      model_lookup(int'(reg_numk), rf_datak, eq, ev);
      total++; if (qk !== eq || vk !== ev) begin bad++; $display("FAIL rnd_k n=%0d got=%0h/%0h exp=%0h/%0h", n, qk, vk, eq, ev); end
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle_inputs();
    model_clear();
    test_reset();
    test_basic();
    test_full_wrap();
    test_out_of_order();
    test_stat_realloc();
    test_reset_midway();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
